// File: rtl/gt_touch_pkg.sv
// Shared definitions for the GT9147/GT9271 touch scanner.
// Holds the register map, the scanner state encoding and helpers that
// decode the status byte and step the read sequence.
package gt_touch_pkg;

  // Controller register map (16-bit register addresses)
  localparam logic [15:0] CTRL  = 16'h8040;
  localparam logic [15:0] CFGS  = 16'h8047;
  localparam logic [15:0] CHECK = 16'h80FF;
  localparam logic [15:0] STAT  = 16'h814E;
  localparam logic [15:0] XL    = 16'h8150;
  localparam logic [15:0] XH    = 16'h8151;
  localparam logic [15:0] YL    = 16'h8152;
  localparam logic [15:0] YH    = 16'h8153;

  localparam int GT_MAX_POINTS = 5;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RD_STAT,
    RD_XL,
    RD_XH,
    RD_YL,
    RD_YH,
    CLR
  } scan_state_t;

  // Point count from the status byte; out-of-range counts read as no touch
  function automatic logic [3:0] stat_points(input logic [7:0] stat);
    if (stat[3:0] > 4'(GT_MAX_POINTS)) return 4'd0;
    return stat[3:0];
  endfunction

  // Register addressed by each transaction state
  function automatic logic [15:0] state_addr(input scan_state_t s);
    case (s)
      RD_XL:   return XL;
      RD_XH:   return XH;
      RD_YL:   return YL;
      RD_YH:   return YH;
      default: return STAT;
    endcase
  endfunction

  // Where an acknowledged transaction leads; rdata only matters for RD_STAT
  function automatic scan_state_t next_after_ack(input scan_state_t s, input logic [7:0] rdata);
    case (s)
      RD_STAT: begin
        if (!rdata[7]) return WAIT;
        if (stat_points(rdata) != 4'd0) return RD_XL;
        return CLR;
      end
      RD_XL:   return RD_XH;
      RD_XH:   return RD_YL;
      RD_YL:   return RD_YH;
      RD_YH:   return CLR;
      default: return WAIT;
    endcase
  endfunction

endpackage

// File: rtl/gt_poll_timer.sv
// Loadable down-counter shared by the poll interval and transaction timeout.
// expired is high whenever the count sits at zero; a load restarts it.
// The count stops at zero until the next load.
module gt_poll_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count;

  // Load takes priority; otherwise count down and rest at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/gt_touch_scan.sv
// Polls the touch controller status, reads point 1 X/Y, clears the status flag,
// and commits the touch point to the outputs atomically after the clear is acknowledged.
// One I2C transaction outstanding at a time; NACK or timeout drops the scan.
module gt_touch_scan
  import gt_touch_pkg::*;
#(
  parameter int POLL_CYCLES = 20000,
  parameter int TO_CYCLES   = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_done,
  output logic        i2c_exec,
  output logic        i2c_rh_wl,
  output logic [15:0] i2c_addr,
  output logic [7:0]  i2c_data_w,
  input  logic [7:0]  i2c_data_r,
  input  logic        once_done,
  input  logic        i2c_ack,
  output logic        touch_valid,
  output logic [3:0]  touch_num,
  output logic [15:0] touch_x,
  output logic [15:0] touch_y,
  output logic        touch_upd,
  output logic [7:0]  err_cnt
);

  localparam int TMAX = (POLL_CYCLES > TO_CYCLES) ? POLL_CYCLES : TO_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  scan_state_t state, state_d;
  logic        busy, busy_d;      // a transaction is outstanding (wait phase)
  logic        issue;             // launch the transaction for the current state
  logic        ack_ok;            // current transaction completed with ACK
  logic        fail;              // current transaction NACKed or timed out
  logic        tmr_load;
  logic [TW-1:0] tmr_value;
  logic        tmr_expired;
  logic [15:0] sh_x, sh_y;        // shadow point, committed only on CLR ACK
  logic [3:0]  sh_num;

  // The poll interval is loaded on every entry to WAIT, the timeout on every issue
  assign tmr_load  = issue || ((state_d == WAIT) && (state != WAIT));
  assign tmr_value = issue ? TW'(TO_CYCLES) : TW'(POLL_CYCLES - 1);

  gt_poll_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (tmr_expired)
  );

  // State and phase registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= busy_d;
    end
  end

  // Next-state: each transaction state issues once, then waits for completion or timeout
  always_comb begin
    state_d = state;
    busy_d  = busy;
    issue   = 1'b0;
    ack_ok  = 1'b0;
    fail    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cfg_done) state_d = WAIT;
      end
      WAIT: begin
        if (!cfg_done)        state_d = IDLE;
        else if (tmr_expired) state_d = RD_STAT;
      end
      default: begin
        if (!busy) begin
          if (!cfg_done) begin
            state_d = IDLE;
          end else begin
            issue  = 1'b1;
            busy_d = 1'b1;
          end
        end else if (once_done) begin
          busy_d = 1'b0;
          if (i2c_ack) begin
            fail    = 1'b1;
            state_d = WAIT;
          end else begin
            ack_ok  = 1'b1;
            state_d = next_after_ack(state, i2c_data_r);
          end
          // a completed transaction still counts, but scanning stops here
          if (!cfg_done) state_d = IDLE;
        end else if (tmr_expired) begin
          busy_d  = 1'b0;
          fail    = 1'b1;
          state_d = cfg_done ? WAIT : IDLE;
        end
      end
    endcase
  end

  // I2C request registers: set on issue and held until the next issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i2c_exec   <= 1'b0;
      i2c_rh_wl  <= 1'b1;
      i2c_addr   <= 16'h0000;
      i2c_data_w <= 8'h00;
    end else begin
      i2c_exec <= issue;
      if (issue) begin
        i2c_addr   <= state_addr(state);
        i2c_rh_wl  <= (state != CLR);
        i2c_data_w <= 8'h00;
      end
    end
  end

  // Error counter saturates rather than wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'h00;
    end else if (fail && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  // Shadow capture and atomic commit; the status read reseeds the shadows from
  // the outputs so a no-point clear keeps the last X/Y
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_x        <= 16'h0000;
      sh_y        <= 16'h0000;
      sh_num      <= 4'd0;
      touch_x     <= 16'h0000;
      touch_y     <= 16'h0000;
      touch_num   <= 4'd0;
      touch_valid <= 1'b0;
      touch_upd   <= 1'b0;
    end else begin
      touch_upd <= 1'b0;
      if (ack_ok) begin
        case (state)
          RD_STAT: begin
            sh_x   <= touch_x;
            sh_y   <= touch_y;
            sh_num <= stat_points(i2c_data_r);
          end
          RD_XL: sh_x[7:0]  <= i2c_data_r;
          RD_XH: sh_x[15:8] <= i2c_data_r;
          RD_YL: sh_y[7:0]  <= i2c_data_r;
          RD_YH: sh_y[15:8] <= i2c_data_r;
          CLR: begin
            touch_x     <= sh_x;
            touch_y     <= sh_y;
            touch_num   <= sh_num;
            touch_valid <= (sh_num != 4'd0);
            touch_upd   <= (sh_x != touch_x) || (sh_y != touch_y) ||
                           (sh_num != touch_num) || ((sh_num != 4'd0) != touch_valid);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gt_touch_scan.sv
// Bench for gt_touch_scan: scripted I2C slave, directed scenarios, then
// randomized polls checked against a per-poll reference model.
module tb_gt_touch_scan;

  localparam int POLL = 20;
  localparam int TO   = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_done = 1'b0;
  logic        i2c_exec, i2c_rh_wl;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_data_w;
  logic [7:0]  i2c_data_r = 8'h00;
  logic        once_done = 1'b0;
  logic        i2c_ack = 1'b0;
  logic        touch_valid, touch_upd;
  logic [3:0]  touch_num;
  logic [15:0] touch_x, touch_y;
  logic [7:0]  err_cnt;

  gt_touch_scan #(.POLL_CYCLES(POLL), .TO_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_done(cfg_done),
    .i2c_exec(i2c_exec), .i2c_rh_wl(i2c_rh_wl), .i2c_addr(i2c_addr),
    .i2c_data_w(i2c_data_w), .i2c_data_r(i2c_data_r), .once_done(once_done),
    .i2c_ack(i2c_ack), .touch_valid(touch_valid), .touch_num(touch_num),
    .touch_x(touch_x), .touch_y(touch_y), .touch_upd(touch_upd), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] data; logic nack; logic hold; int dly; } resp_t;
  typedef struct { logic [15:0] addr; logic rw; logic [7:0] dw; int at; int gap; } txn_t;

  resp_t resp_q[$];
  txn_t  log_q[$];
  int    last_done = 0;
  bit    slave_busy = 1'b0;
  int    upd_cnt = 0;
  int    dbl_exec = 0;
  logic  prev_exec = 1'b0;
  int    checks = 0;
  int    errors = 0;

  resp_t s_r;
  txn_t  s_t;

  // I2C slave: log every exec, answer from the script (default: status 0x00)
  always begin
    @(negedge clk);
    if (rst_n && i2c_exec) begin
      s_t.addr = i2c_addr; s_t.rw = i2c_rh_wl; s_t.dw = i2c_data_w;
      s_t.at = cyc; s_t.gap = cyc - last_done;
      log_q.push_back(s_t);
      if (resp_q.size() != 0) s_r = resp_q.pop_front();
      else s_r = '{data: 8'h00, nack: 1'b0, hold: 1'b0, dly: 1};
      if (!s_r.hold) begin
        slave_busy = 1'b1;
        repeat (s_r.dly - 1) @(negedge clk);
        @(negedge clk);
        once_done = 1'b1; i2c_data_r = s_r.data; i2c_ack = s_r.nack; last_done = cyc;
        @(negedge clk);
        once_done = 1'b0; i2c_ack = 1'b0;
        slave_busy = 1'b0;
      end
    end
  end

  // Output monitors
  always @(negedge clk) begin
    if (touch_upd) upd_cnt++;
    if (i2c_exec && prev_exec) dbl_exec++;
    prev_exec = i2c_exec;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic nack, input logic hold, input int dly);
    resp_t r;
    r.data = d; r.nack = nack; r.hold = hold; r.dly = dly;
    resp_q.push_back(r);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while ((resp_q.size() != 0 || slave_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_bound"}, (n < budget) ? 32'd1 : 32'd0, 32'd1);
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_log(input string tag, input int cnt, input int budget);
    int n = 0;
    while (log_q.size() < cnt && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_bound"}, (n < budget) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic chk_out(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic [3:0] num, input logic vld, input logic [7:0] err);
    chk({tag, "_x"}, touch_x, x);
    chk({tag, "_y"}, touch_y, y);
    chk({tag, "_num"}, touch_num, num);
    chk({tag, "_valid"}, touch_valid, vld);
    chk({tag, "_err"}, err_cnt, err);
  endtask

  logic [15:0] dir_a[6];
  logic        dir_rw[6];
  logic [15:0] m_x, m_y;
  logic [3:0]  m_num;
  logic        m_valid;
  int          m_err;

  initial begin
    // ---- reset values ----
    repeat (3) @(negedge clk);
    chk("rst_exec", i2c_exec, 0);
    chk("rst_rw", i2c_rh_wl, 1);
    chk("rst_addr", i2c_addr, 0);
    chk("rst_dw", i2c_data_w, 0);
    chk("rst_upd", touch_upd, 0);
    chk_out("rst", 16'h0, 16'h0, 4'd0, 1'b0, 8'd0);
    rst_n = 1'b1;

    // ---- IDLE holds while cfg_done is low ----
    repeat (3 * POLL) @(negedge clk);
    chk("idle_no_exec", log_q.size(), 0);

    // ---- status 0x00: single read, no XL, no CLR, period POLL+2 from done ----
    cfg_done = 1'b1;
    push(8'h00, 1'b0, 1'b0, 2);
    wait_done("st0a", 200);
    chk("st0a_len", log_q.size(), 1);
    chk("st0a_addr", log_q[0].addr, 16'h814E);
    chk("st0a_rw", log_q[0].rw, 1);
    log_q.delete();
    push(8'h00, 1'b0, 1'b0, 3);
    wait_done("st0b", 200);
    chk("st0b_len", log_q.size(), 1);
    chk("st0b_period", log_q[0].gap, POLL + 2);
    chk_out("st0", 16'h0, 16'h0, 4'd0, 1'b0, 8'd0);
    chk("st0_upd", upd_cnt, 0);

    // ---- one touch: 0x81, X=0x0120, Y=0x0258 ----
    log_q.delete(); upd_cnt = 0;
    push(8'h81, 0, 0, 2); push(8'h20, 0, 0, 1); push(8'h01, 0, 0, 3);
    push(8'h58, 0, 0, 1); push(8'h02, 0, 0, 2); push(8'h00, 0, 0, 1);
    wait_done("t1", 400);
    dir_a  = '{16'h814E, 16'h8150, 16'h8151, 16'h8152, 16'h8153, 16'h814E};
    dir_rw = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    chk("t1_len", log_q.size(), 6);
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      chk($sformatf("t1_addr%0d", i), log_q[i].addr, dir_a[i]);
      chk($sformatf("t1_rw%0d", i), log_q[i].rw, dir_rw[i]);
      if (i > 0) chk($sformatf("t1_gap%0d", i), log_q[i].gap, 2);
    end
    if (log_q.size() == 6) chk("t1_clr_data", log_q[5].dw, 8'h00);
    chk_out("t1", 16'h0120, 16'h0258, 4'd1, 1'b1, 8'd0);
    chk("t1_upd", upd_cnt, 1);

    // ---- release: 0x80 clears, X/Y hold ----
    log_q.delete(); upd_cnt = 0;
    push(8'h80, 0, 0, 1); push(8'h00, 0, 0, 2);
    wait_done("rel", 300);
    chk("rel_len", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("rel_clr_addr", log_q[1].addr, 16'h814E);
      chk("rel_clr_rw", log_q[1].rw, 0);
    end
    chk_out("rel", 16'h0120, 16'h0258, 4'd0, 1'b0, 8'd0);
    chk("rel_upd", upd_cnt, 1);

    // ---- NACK on YL ----
    log_q.delete(); upd_cnt = 0;
    push(8'h83, 0, 0, 1); push(8'h11, 0, 0, 1); push(8'h22, 0, 0, 1); push(8'h33, 1, 0, 2);
    wait_done("nack", 300);
    chk("nack_len", log_q.size(), 4);
    chk_out("nack", 16'h0120, 16'h0258, 4'd0, 1'b0, 8'd1);
    chk("nack_upd", upd_cnt, 0);
    log_q.delete();
    push(8'h00, 0, 0, 1);
    wait_done("nack_next", 200);
    chk("nack_next_len", log_q.size(), 1);
    chk("nack_next_period", log_q[0].gap, POLL + 2);

    // ---- withheld once_done: timeout ----
    log_q.delete(); upd_cnt = 0;
    push(8'h00, 0, 1, 0); push(8'h00, 0, 0, 1);
    wait_log("to", 2, TO + POLL + 100);
    wait_done("to", 100);
    chk("to_err", err_cnt, 2);
    if (log_q.size() >= 2) begin
      chk("to_period", log_q[1].at - log_q[0].at, TO + POLL + 2);
      chk("to_next_addr", log_q[1].addr, 16'h814E);
    end
    chk("to_upd", upd_cnt, 0);

    // ---- randomized polls against the reference model ----
    m_x = 16'h0120; m_y = 16'h0258; m_num = 4'd0; m_valid = 1'b0; m_err = 2;
    for (int it = 0; it < 12; it++) begin
      logic [7:0]  st;
      logic [7:0]  b[4];
      logic [15:0] ea[6];
      logic        erw[6];
      logic [15:0] nx, ny;
      int n, nk, pts, nn, exp_len, exp_upd;
      st = 8'($urandom_range(0, 255));
      if (it < 8) st[7] = 1'b1;
      for (int k = 0; k < 4; k++) b[k] = 8'($urandom_range(0, 255));
      pts = int'(st[3:0]);
      ea[0] = 16'h814E; erw[0] = 1'b1;
      if (!st[7]) begin
        n = 1;
      end else if (pts >= 1 && pts <= 5) begin
        n = 6;
        ea[1] = 16'h8150; ea[2] = 16'h8151; ea[3] = 16'h8152; ea[4] = 16'h8153; ea[5] = 16'h814E;
        erw[1] = 1'b1; erw[2] = 1'b1; erw[3] = 1'b1; erw[4] = 1'b1; erw[5] = 1'b0;
      end else begin
        n = 2; ea[1] = 16'h814E; erw[1] = 1'b0;
      end
      nk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      exp_len = (nk < 0) ? n : nk + 1;
      for (int k = 0; k < exp_len; k++)
        push((k == 0) ? st : ((n == 6 && k <= 4) ? b[k-1] : 8'h00), (k == nk), 1'b0,
             int'($urandom_range(1, 3)));
      exp_upd = 0;
      if (nk >= 0) begin
        if (m_err < 255) m_err++;
      end else if (st[7]) begin
        nn = (pts >= 1 && pts <= 5) ? pts : 0;
        nx = (nn != 0) ? {b[1], b[0]} : m_x;
        ny = (nn != 0) ? {b[3], b[2]} : m_y;
        exp_upd = ((nx != m_x) || (ny != m_y) || (nn != int'(m_num)) || ((nn != 0) != m_valid)) ? 1 : 0;
        m_x = nx; m_y = ny; m_num = 4'(nn); m_valid = (nn != 0);
      end
      log_q.delete(); upd_cnt = 0;
      wait_done($sformatf("rnd%0d", it), 8 * (POLL + 10));
      chk($sformatf("rnd%0d_len", it), log_q.size(), exp_len);
      for (int k = 0; k < exp_len && k < log_q.size(); k++) begin
        chk($sformatf("rnd%0d_addr%0d", it, k), log_q[k].addr, ea[k]);
        chk($sformatf("rnd%0d_rw%0d", it, k), log_q[k].rw, erw[k]);
      end
      chk_out($sformatf("rnd%0d", it), m_x, m_y, m_num, m_valid, 8'(m_err));
      chk($sformatf("rnd%0d_upd", it), upd_cnt, exp_upd);
    end

    // ---- asynchronous reset while RD_XH is outstanding ----
    log_q.delete();
    push(8'h82, 0, 0, 1); push(8'h44, 0, 0, 1); push(8'h00, 0, 1, 0);
    wait_log("arst", 3, 4 * POLL + 100);
    if (log_q.size() >= 3) chk("arst_xh_addr", log_q[2].addr, 16'h8151);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_exec", i2c_exec, 0);
    chk("arst_rw", i2c_rh_wl, 1);
    chk("arst_addr", i2c_addr, 0);
    chk("arst_dw", i2c_data_w, 0);
    chk("arst_upd", touch_upd, 0);
    chk_out("arst", 16'h0, 16'h0, 4'd0, 1'b0, 8'd0);
    cfg_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * POLL) @(negedge clk);
    chk("arst_idle_len", log_q.size(), 3);
    chk("double_exec", dbl_exec, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gt_touch_scan.md
# gt_touch_scan

Polling reader for the GT9147/GT9271 capacitive touch controller. It runs after register configuration completes (`cfg_done`). It drives the shared single-byte I2C master (`i2c_dri`) to read the point-status register, fetch the first touch point's coordinates, and clear the status flag. It presents a held, atomically updated touch point to the GUI/Nios II side.

## Interface
Parameters:
- `POLL_CYCLES`, 20000: idle clocks between status polls (20 ms at the 1 MHz driver clock); minimum 2.
- `TO_CYCLES`, 4095: clocks to wait for `once_done` before a transaction is declared lost.

Ports:
- `clk` in 1: driver clock, same 1 MHz clock as the I2C master.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cfg_done` in 1: configuration finished; scanning enabled while high.
- `i2c_exec` out 1: one-cycle transaction start pulse to the I2C master.
- `i2c_rh_wl` out 1: 1 = read, 0 = write.
- `i2c_addr` out 16: 16-bit register address.
- `i2c_data_w` out 8: write data.
- `i2c_data_r` in 8: read data; valid in the cycle `once_done` = 1.
- `once_done` in 1: one-cycle transaction-complete pulse.
- `i2c_ack` in 1: 0 = acknowledged, 1 = NACK; sampled with `once_done`.
- `touch_valid` out 1: 1 while at least one finger is reported.
- `touch_num` out 4: number of points reported, 0–5.
- `touch_x` out 16: point-1 X coordinate.
- `touch_y` out 16: point-1 Y coordinate.
- `touch_upd` out 1: one-cycle pulse when any touch output changes.
- `err_cnt` out 8: saturating count of NACK or timeout events.

## Operation
- Register map:
  - `STAT` = 0x814E: bit7 = buffer ready; bits[3:0] = number of points.
  - `XL`/`XH`/`YL`/`YH` = 0x8150/0x8151/0x8152/0x8153.
- States: `IDLE`, `WAIT`, `RD_STAT`, `RD_XL`, `RD_XH`, `RD_YL`, `RD_YH`, `CLR`.
- Each transaction state has two phases:
  - Issue: one-cycle `i2c_exec` with `i2c_addr`/`i2c_rh_wl`/`i2c_data_w` set.
  - Wait: hold until `once_done`.
  - Address, direction and data stay stable from the issue cycle until `once_done`.
- `IDLE`: go to `WAIT` when `cfg_done` = 1.
- `WAIT`: count `POLL_CYCLES`, then go to `RD_STAT`.
- `RD_STAT` (`once_done`, ACK):
  - bit7 = 0: return to `WAIT`; outputs unchanged.
  - bit7 = 1 and points = 0: go to `CLR` with pending `touch_num` = 0, `touch_valid` = 0.
  - bit7 = 1 and points in 1..5: latch points, then go to `RD_XL`.
  - bit7 = 1 and points > 5: treat as 0.
- `RD_XL` → `RD_XH` → `RD_YL` → `RD_YH`: bytes go to shadow registers.
  - `{XH,XL}` forms X and `{YH,YL}` forms Y; 16-bit values, no scaling.
- After `RD_YH`, go to `CLR`.
- `CLR`: write 0x00 to `STAT`. On ACK:
  - Commit shadow X/Y, `touch_num` and `touch_valid` in a single cycle.
  - Pulse `touch_upd` if any committed value differs from the current output.
  - Go to `WAIT`.
- NACK on any transaction, or timeout (`TO_CYCLES` with no `once_done`):
  - Increment `err_cnt` (saturates at 255).
  - Discard shadows and go to `WAIT`; outputs unchanged.
- `cfg_done` falling mid-sequence: finish the current transaction, then go to `IDLE`; outputs hold.
- `once_done` arriving outside a wait phase is ignored.

## Timing
- Reset values:
  - `i2c_exec` = 0, `i2c_rh_wl` = 1, `i2c_addr` = 0, `i2c_data_w` = 0.
  - `touch_valid` = 0, `touch_num` = 0, `touch_x` = 0, `touch_y` = 0, `touch_upd` = 0, `err_cnt` = 0.
  - State = `IDLE`.
- `i2c_exec` rises exactly one clock after entering a transaction state. It is never asserted two cycles in a row, and never while a transaction is outstanding.
- `once_done` at cycle n:
  - Next state is entered at n+1.
  - Next `i2c_exec` is at n+2.
- Commit: outputs update in the cycle after the `CLR` `once_done`; `touch_upd` is high in that same cycle.
- Poll period: `POLL_CYCLES` from entering `WAIT` to the `RD_STAT` issue, plus 1.
- Asynchronous reset mid-transaction: `i2c_exec` drops immediately; no completion is expected afterwards.

## Structure
- Shared package `gt_touch_pkg`:
  - Register address constants (`STAT`, `XL`..`YH`, plus the existing `CTRL`/`CFGS`/`CHECK`).
  - State encoding.
  - `GT_MAX_POINTS` = 5.
- Sub-module `gt_poll_timer`: loadable down-counter shared by the poll interval and the transaction timeout, with outputs `expired` and `load`/`value` inputs.

## Test plan
- Status read returns 0x00 → no `XL` read issued; next `RD_STAT` follows after `POLL_CYCLES`; outputs stay 0; no `CLR`.
- Status 0x81, bytes 0x20, 0x01, 0x58, 0x02 → exec sequence 814E R, 8150 R, 8151 R, 8152 R, 8153 R, 814E W 0x00; then `touch_x` = 0x0120, `touch_y` = 0x0258, `touch_num` = 1, `touch_valid` = 1, one `touch_upd` pulse.
- After that touch, status 0x80 → `CLR` issued; `touch_valid` = 0, `touch_num` = 0, X/Y hold 0x0120/0x0258, `touch_upd` pulses.
- NACK on `RD_YL` → `err_cnt` = 1, no `CLR`, outputs unchanged, next poll proceeds normally.
- Model withholds `once_done` → after `TO_CYCLES`, `err_cnt` increments and the FSM returns to `WAIT`. Also: `rst_n` low mid-`RD_XH` → all outputs at reset values, state `IDLE`.
